// File: rtl/stride_value_predictor_pkg.sv
// vp_pkg: shared types for the stride value predictor.
//   vp_mode_e  : prediction mode (last-value or stride)
//   vp_state_e : table-clear walk / normal operation
//   vp_entry_t : entry layout for the default geometry (8-bit tag, 2-bit
//                confidence); the top level rebuilds the same layout from its
//                own parameters so non-default geometries stay consistent.
// ADDR_WIDTH / DATA_WIDTH follow the core-wide macros when mips_core.svh has
// been included ahead of this file; otherwise 32-bit defaults apply.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vp_pkg;
  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int DATA_WIDTH = `DATA_WIDTH;

  localparam int VP_TAG_W_DEF  = 8;
  localparam int VP_CONF_W_DEF = 2;

  typedef enum logic {
    VP_LAST   = 1'b0,
    VP_STRIDE = 1'b1
  } vp_mode_e;

  typedef enum logic {
    VP_CLEAR = 1'b0,
    VP_RUN   = 1'b1
  } vp_state_e;

  typedef struct packed {
    logic                     valid;
    logic [VP_TAG_W_DEF-1:0]  tag;
    logic [DATA_WIDTH-1:0]    last;
    logic [DATA_WIDTH-1:0]    stride;
    logic [VP_CONF_W_DEF-1:0] conf;
  } vp_entry_t;
endpackage

// File: rtl/stride_value_predictor_table.sv
// vp_table: entry storage for the stride value predictor.
//   clk       : write clock
//   rd_a_idx  : lookup read index      -> rd_a_data (combinational)
//   rd_b_idx  : resolve read index     -> rd_b_data (combinational)
//   we/wr_idx/wr_data : the single write port, shared by training and clear walk
// Entries are stored as flat vectors; the top level owns the field layout.
// Storage has no reset: the clear walk invalidates every entry after reset.
module vp_table #(
  parameter int INDEX_WIDTH = 6,
  parameter int ENTRY_W     = 75
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] rd_a_idx,
  output logic [ENTRY_W-1:0]     rd_a_data,
  input  logic [INDEX_WIDTH-1:0] rd_b_idx,
  output logic [ENTRY_W-1:0]     rd_b_data,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [ENTRY_W-1:0]     wr_data
);
  logic [ENTRY_W-1:0] mem [2**INDEX_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_a_data = mem[rd_a_idx];
  assign rd_b_data = mem[rd_b_idx];
endmodule

// File: rtl/stride_value_predictor.sv
// stride_value_predictor: PC-indexed load value predictor (last value, stride,
// confidence per tagged entry). Lookups produce registered predictions one
// cycle later; resolves train the table and flag consumed mispredictions.
// Ports:
//   clk, rst (sync, active-high), flush (restart the table-clear walk)
//   ready                 : 1 while in RUN
//   lookup_valid/pc       : prediction request
//   pred_valid/confident/value : registered prediction for last cycle's lookup
//   resolve_valid/pc/value/used/pred_value : returned load data for training
//   mispredict/recover_value : registered pulse + correct value
module stride_value_predictor
  import vp_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2,
  parameter int MODE        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  ready,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_confident,
  output logic [DATA_WIDTH-1:0] pred_value,
  input  logic                  resolve_valid,
  input  logic [ADDR_WIDTH-1:0] resolve_pc,
  input  logic [DATA_WIDTH-1:0] resolve_value,
  input  logic                  resolve_used,
  input  logic [DATA_WIDTH-1:0] resolve_pred_value,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] recover_value
);
  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] last;
    logic [DATA_WIDTH-1:0] stride;
    logic [CONF_BITS-1:0]  conf;
  } entry_t;

  localparam int                     ENTRY_W  = $bits(entry_t);
  localparam int                     TAG_LSB  = INDEX_WIDTH + 2;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [CONF_BITS-1:0]   CONF_MAX = '1;
  localparam logic [CONF_BITS-1:0]   CONF_TH  = CONF_BITS'(CONF_THRESH);
  localparam vp_mode_e               MODE_E   = vp_mode_e'(MODE[0]);

  function automatic logic [INDEX_WIDTH-1:0] idx_of(input logic [ADDR_WIDTH-1:0] pc);
    return pc[INDEX_WIDTH+1:2];
  endfunction

  function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [ADDR_WIDTH-1:0] pc);
    return pc[TAG_LSB+TAG_WIDTH-1:TAG_LSB];
  endfunction

  function automatic logic [CONF_BITS-1:0] conf_sat_inc(input logic [CONF_BITS-1:0] c);
    return (c == CONF_MAX) ? c : c + 1'b1;
  endfunction

  // PC bits outside index/tag take no part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[ADDR_WIDTH-1:TAG_LSB+TAG_WIDTH],
                            resolve_pc[1:0], resolve_pc[ADDR_WIDTH-1:TAG_LSB+TAG_WIDTH]};

  vp_state_e              state_q, state_d;
  logic [INDEX_WIDTH-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= VP_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      VP_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) state_d = VP_RUN;
      end
      VP_RUN: begin
        if (flush) begin
          state_d   = VP_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state_q == VP_RUN);

  logic [INDEX_WIDTH-1:0] lk_idx, rs_idx, wr_idx;
  logic [TAG_WIDTH-1:0]   lk_tag, rs_tag;
  logic [ENTRY_W-1:0]     lk_raw, rs_raw;
  entry_t                 lk_e, rs_e, rs_new, lk_fwd, wr_e;
  logic [DATA_WIDTH-1:0]  rs_pred;
  logic                   train_we, we;

  assign lk_idx = idx_of(lookup_pc);
  assign lk_tag = tag_of(lookup_pc);
  assign rs_idx = idx_of(resolve_pc);
  assign rs_tag = tag_of(resolve_pc);
  assign lk_e   = entry_t'(lk_raw);
  assign rs_e   = entry_t'(rs_raw);

  // flush wins over a same-cycle resolve; the clear walk owns the write port.
  assign train_we = (state_q == VP_RUN) && resolve_valid && !flush;

  always_comb begin
    rs_pred = rs_e.last + rs_e.stride;
    rs_new  = '0;
    rs_new.valid = 1'b1;
    rs_new.tag   = rs_tag;
    rs_new.last  = resolve_value;
    if (rs_e.valid && (rs_e.tag == rs_tag)) begin
      rs_new.conf   = (resolve_value == rs_pred) ? conf_sat_inc(rs_e.conf) : '0;
      rs_new.stride = (MODE_E == VP_STRIDE) ? resolve_value - rs_e.last : '0;
    end
  end

  always_comb begin
    we     = train_we;
    wr_idx = rs_idx;
    wr_e   = rs_new;
    if (state_q == VP_CLEAR) begin
      we     = 1'b1;
      wr_idx = clr_idx_q;
      wr_e   = '0;
    end
  end

  vp_table #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .ENTRY_W    (ENTRY_W)
  ) u_table (
    .clk      (clk),
    .rd_a_idx (lk_idx),
    .rd_a_data(lk_raw),
    .rd_b_idx (rs_idx),
    .rd_b_data(rs_raw),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_data  (wr_e)
  );

  // A same-cycle resolve to the looked-up index is seen post-update,
  // including its new tag.
  assign lk_fwd = (train_we && (rs_idx == lk_idx)) ? rs_new : lk_e;

  logic hit_p0, mis_p0;
  assign hit_p0 = lookup_valid && (state_q == VP_RUN) && lk_fwd.valid && (lk_fwd.tag == lk_tag);
  assign mis_p0 = resolve_valid && resolve_used && (resolve_value != resolve_pred_value);

  // ---- stage p0 -> p1: registered outputs ----
  logic                  vld_p1, conf_p1, mis_p1;
  logic [DATA_WIDTH-1:0] value_p1, rec_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      conf_p1  <= 1'b0;
      value_p1 <= '0;
      mis_p1   <= 1'b0;
      rec_p1   <= '0;
    end else begin
      vld_p1   <= hit_p0;
      conf_p1  <= hit_p0 && (lk_fwd.conf >= CONF_TH);
      value_p1 <= hit_p0 ? lk_fwd.last + lk_fwd.stride : '0;
      mis_p1   <= mis_p0;
      if (mis_p0) rec_p1 <= resolve_value;
    end
  end

  assign pred_valid     = vld_p1;
  assign pred_confident = conf_p1;
  assign pred_value     = value_p1;
  assign mispredict     = mis_p1;
  assign recover_value  = rec_p1;
endmodule

// File: tb/tb_stride_value_predictor.sv
module tb_stride_value_predictor;
  localparam int AW = vp_pkg::ADDR_WIDTH;
  localparam int DW = vp_pkg::DATA_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, lookup_valid, resolve_valid, resolve_used;
  logic [AW-1:0] lookup_pc, resolve_pc;
  logic [DW-1:0] resolve_value, resolve_pred_value;

  logic          ready, pred_valid, pred_confident, mispredict;
  logic [DW-1:0] pred_value, recover_value;
  logic          ready0, pred_valid0, pred_confident0, mispredict0;
  logic [DW-1:0] pred_value0, recover_value0;

  stride_value_predictor #(.MODE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_confident(pred_confident), .pred_value(pred_value),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_value(resolve_value),
    .resolve_used(resolve_used), .resolve_pred_value(resolve_pred_value),
    .mispredict(mispredict), .recover_value(recover_value)
  );

  stride_value_predictor #(.MODE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready0),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid0), .pred_confident(pred_confident0), .pred_value(pred_value0),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_value(resolve_value),
    .resolve_used(resolve_used), .resolve_pred_value(resolve_pred_value),
    .mispredict(mispredict0), .recover_value(recover_value0)
  );

  typedef struct {
    logic          lv;
    logic [31:0]   lpc;
    logic          rv;
    logic [31:0]   rpc;
    logic [31:0]   rval;
    logic          used;
    logic [31:0]   upv;
    logic          e_pv;
    logic          e_pc;
    logic [31:0]   e_val;
    logic          e_mis;
    logic [31:0]   e_rec;
    logic          e0_pv;
    logic          e0_pc;
    logic [31:0]   e0_val;
  } vec_t;

  typedef struct {
    int          id;
    logic        pv, pc, mis, pv0, pc0;
    logic [31:0] val, rec, val0;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; lookup_valid = 0; lookup_pc = '0;
    resolve_valid = 0; resolve_pc = '0; resolve_value = '0;
    resolve_used = 0; resolve_pred_value = '0;
  endtask

  // Counts cycles until ready rises; expects exactly 64 with quiet outputs.
  task automatic walk_count(input string nm);
    int cnt = 0;
    logic noisy = 0;
    while (!ready && cnt < 200) begin
      step();
      cnt++;
      if (!ready && (pred_valid | pred_confident | mispredict | (|pred_value) | (|recover_value)))
        noisy = 1;
    end
    chk({nm, " walk cycles"}, cnt, 64);
    chk({nm, " outputs quiet"}, {31'b0, noisy}, 0);
    chk({nm, " ready0"}, {31'b0, ready0}, 1);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   spc[4];

    //        lv  lpc      rv  rpc      rval  used upv | pv pc val mis rec | d0 pv pc val
    vecs[0]  = '{1, 32'h200,  1, 32'h200,  32'h55, 0, 0,  1, 0, 32'h55, 0, 0,  1, 0, 32'h55};
    vecs[1]  = '{0, 0,        1, 32'h100,  10,     0, 0,  0, 0, 0,      0, 0,  0, 0, 0};
    vecs[2]  = '{0, 0,        1, 32'h100,  14,     0, 0,  0, 0, 0,      0, 0,  0, 0, 0};
    vecs[3]  = '{0, 0,        1, 32'h100,  18,     0, 0,  0, 0, 0,      0, 0,  0, 0, 0};
    vecs[4]  = '{0, 0,        1, 32'h100,  22,     0, 0,  0, 0, 0,      0, 0,  0, 0, 0};
    vecs[5]  = '{1, 32'h100,  0, 0,        0,      0, 0,  1, 1, 26,     0, 0,  1, 0, 22};
    vecs[6]  = '{0, 0,        1, 32'h4100, 32'h77, 0, 0,  0, 0, 0,      0, 0,  0, 0, 0};
    vecs[7]  = '{1, 32'h100,  0, 0,        0,      0, 0,  0, 0, 0,      0, 0,  0, 0, 0};
    vecs[8]  = '{1, 32'h4100, 0, 0,        0,      0, 0,  1, 0, 32'h77, 0, 0,  1, 0, 32'h77};
    vecs[9]  = '{0, 0,        1, 32'h304,  7,      1, 5,  0, 0, 0,      1, 7,  0, 0, 0};
    vecs[10] = '{0, 0,        0, 0,        0,      0, 0,  0, 0, 0,      0, 7,  0, 0, 0};
    vecs[11] = '{0, 0,        1, 32'h304,  9,      1, 9,  0, 0, 0,      0, 7,  0, 0, 0};
    vecs[12] = '{1, 32'h304,  0, 0,        0,      0, 0,  1, 0, 11,     0, 7,  1, 0, 9};
    vecs[13] = '{1, 32'h304,  1, 32'h304,  11,     1, 11, 1, 0, 13,     0, 7,  1, 0, 11};
    vecs[14] = '{1, 32'h304,  1, 32'h304,  13,     0, 0,  1, 1, 15,     0, 7,  1, 0, 13};
    vecs[15] = '{0, 32'h304,  0, 0,        0,      0, 0,  0, 0, 0,      0, 7,  0, 0, 0};

    idle_inputs();
    rst = 1;
    repeat (3) step();
    chk("reset ready",          {31'b0, ready},          0);
    chk("reset pred_valid",     {31'b0, pred_valid},     0);
    chk("reset pred_confident", {31'b0, pred_confident}, 0);
    chk("reset pred_value",     pred_value,              0);
    chk("reset mispredict",     {31'b0, mispredict},     0);
    chk("reset recover_value",  recover_value,           0);

    rst = 0;
    walk_count("post-reset");

    // Reset in the middle of a walk restarts it from index 0.
    flush = 1; step(); flush = 0;
    repeat (10) step();
    rst = 1; step(); rst = 0;
    chk("mid-walk reset ready", {31'b0, ready}, 0);
    walk_count("restarted");

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      lookup_valid = v.lv; lookup_pc = v.lpc;
      resolve_valid = v.rv; resolve_pc = v.rpc; resolve_value = v.rval;
      resolve_used = v.used; resolve_pred_value = v.upv;
      sb.push_back('{i, v.e_pv, v.e_pc, v.e_mis, v.e0_pv, v.e0_pc, v.e_val, v.e_rec, v.e0_val});
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d pred_valid", e.id),      {31'b0, pred_valid},      {31'b0, e.pv});
      chk($sformatf("v%0d pred_confident", e.id),  {31'b0, pred_confident},  {31'b0, e.pc});
      chk($sformatf("v%0d pred_value", e.id),      pred_value,               e.val);
      chk($sformatf("v%0d mispredict", e.id),      {31'b0, mispredict},      {31'b0, e.mis});
      chk($sformatf("v%0d recover_value", e.id),   recover_value,            e.rec);
      chk($sformatf("v%0d mode0 pred_valid", e.id), {31'b0, pred_valid0},    {31'b0, e.pv0});
      chk($sformatf("v%0d mode0 confident", e.id), {31'b0, pred_confident0}, {31'b0, e.pc0});
      chk($sformatf("v%0d mode0 pred_value", e.id), pred_value0,             e.val0);
      chk($sformatf("v%0d mode0 mispredict", e.id), {31'b0, mispredict0},    {31'b0, e.mis});
    end
    idle_inputs();

    // flush with a same-cycle consumed, wrong resolve: pulse still fires.
    flush = 1;
    resolve_valid = 1; resolve_pc = 32'h4100; resolve_value = 32'h99;
    resolve_used = 1; resolve_pred_value = 32'h98;
    step();
    idle_inputs();
    chk("flush mispredict",    {31'b0, mispredict}, 1);
    chk("flush recover_value", recover_value,       32'h99);
    chk("flush ready drop",    {31'b0, ready},      0);

    for (int i = 0; i < 64; i++) begin
      lookup_valid = 1; lookup_pc = 32'h304;
      resolve_valid = 0; resolve_used = 0;
      if (i == 5) begin
        resolve_valid = 1; resolve_pc = 32'h4100; resolve_value = 32'h33;
        resolve_used = 1; resolve_pred_value = 0;
      end
      if (i == 63) begin
        resolve_valid = 1; resolve_pc = 32'h100; resolve_value = 32'h11;
      end
      step();
      if (pred_valid !== 1'b0) chk($sformatf("clear%0d pred_valid", i), {31'b0, pred_valid}, 0);
      if (i == 5) begin
        chk("clear mispredict",    {31'b0, mispredict}, 1);
        chk("clear recover_value", recover_value,       32'h33);
      end
      if (i == 62) chk("clear ready before end", {31'b0, ready}, 0);
      if (i == 63) chk("clear ready at end",     {31'b0, ready}, 1);
    end
    chk("clear lookups suppressed", {31'b0, pred_valid | pred_confident}, 0);
    idle_inputs();

    spc[0] = 32'h100; spc[1] = 32'h4100; spc[2] = 32'h304; spc[3] = 32'h200;
    for (int i = 0; i < 4; i++) begin
      lookup_valid = 1; lookup_pc = spc[i];
      step();
      chk($sformatf("post-flush 0x%0h pred_valid", spc[i]), {31'b0, pred_valid}, 0);
      chk($sformatf("post-flush 0x%0h pred_value", spc[i]), pred_value,         0);
    end
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
